// File: rtl/boot_sequencer_if.sv
// Boot sequencer bus: boot request, per-core start PCs and halt flags in,
// per-core resets, latched start PCs and status out.
// master = board/bench side, slave = sequencer side.
interface boot_sequencer_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32
);
  logic                        start;
  logic [NUM_CORES*ADDR_W-1:0] boot_addr_in;
  logic [NUM_CORES-1:0]        core_halted;
  logic [NUM_CORES-1:0]        core_rst;
  logic [NUM_CORES*ADDR_W-1:0] startPC;
  logic                        busy;
  logic                        done;
  logic                        timeout;
  logic [31:0]                 cycle_count;

  modport master (
    output start, boot_addr_in, core_halted,
    input  core_rst, startPC, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, boot_addr_in, core_halted,
    output core_rst, startPC, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds all cores in reset, releases them one by one with
// latched start PCs, then supervises the run until every core halts or the
// run budget expires.
// Optional feature macro: BOOT_SEQ_PERF_CNT_EN exposes the run-cycle counter
// on cycle_count; without it cycle_count reads 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | after reset, all cores in reset, waiting for start
// S_HOLD    | all cores held in reset for HOLD_CYCLES
// S_RELEASE | dropping core resets in index order, STAGGER apart
// S_RUN     | all cores running, counting run cycles
// S_DONE    | run finished (halt or budget), cores back in reset
module boot_sequencer #(
  parameter int NUM_CORES   = 2,
  parameter int ADDR_W      = 32,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int RUN_CYCLES  = 1000
) (
  input logic            CLK,
  input logic            RESET,
  boot_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                      state_q;
  logic [31:0]                 tmr_q;
  logic [IDX_W-1:0]            idx_q;
  logic [31:0]                 run_cnt_q;
  logic [31:0]                 run_cnt_d;
  logic [NUM_CORES-1:0]        core_rst_q;
  logic [NUM_CORES*ADDR_W-1:0] start_pc_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        timeout_q;
  logic                        all_halted;
  logic                        budget_hit;

  // Saturating run counter increment; budget compares against the value
  // the counter would take on this edge.
  assign run_cnt_d  = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
  assign all_halted = &bus.core_halted;
  assign budget_hit = (RUN_CYCLES != 0) && (run_cnt_d == 32'(RUN_CYCLES));

  // Sequencing FSM with registered outputs; async reset forces cores into reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      run_cnt_q  <= '0;
      core_rst_q <= '1;
      start_pc_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_HOLD;
            start_pc_q <= bus.boot_addr_in;
            tmr_q      <= 32'(HOLD_CYCLES - 1);
            idx_q      <= '0;
            run_cnt_q  <= '0;
            core_rst_q <= '1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (tmr_q == 32'd0) begin
            core_rst_q[0] <= 1'b0;
            if (NUM_CORES == 1) begin
              state_q   <= S_RUN;
              run_cnt_q <= '0;
            end else begin
              state_q <= S_RELEASE;
              idx_q   <= IDX_W'(1);
              tmr_q   <= 32'(STAGGER - 1);
            end
          end else begin
            tmr_q <= tmr_q - 32'd1;
          end
        end
        S_RELEASE: begin
          if (tmr_q == 32'd0) begin
            core_rst_q[idx_q] <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q   <= S_RUN;
              run_cnt_q <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              tmr_q <= 32'(STAGGER - 1);
            end
          end else begin
            tmr_q <= tmr_q - 32'd1;
          end
        end
        S_RUN: begin
          // Halt takes priority over budget expiry on the same edge; the
          // counter is frozen on a halt exit so it reports completed cycles.
          if (all_halted) begin
            state_q    <= S_DONE;
            core_rst_q <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_d;
            if (budget_hit) begin
              state_q    <= S_DONE;
              core_rst_q <= '1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              timeout_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= '1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_rst = core_rst_q;
  assign bus.startPC  = start_pc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

`ifdef BOOT_SEQ_PERF_CNT_EN
  assign bus.cycle_count = run_cnt_q;
`else
  assign bus.cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer (NUM_CORES=2, HOLD=16, STAGGER=4, RUN=1000).
// Expected values go into a scoreboard queue when stimulus is applied and are
// popped and compared when the DUT output is sampled.
module tb_boot_sequencer;

  logic clk;
  logic rst;
  int   n;
  int   tests;
  int   failed;

`ifdef BOOT_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic [127:0] exp_q[$];
  string        tag_q[$];

  boot_sequencer_if #(.NUM_CORES(2), .ADDR_W(32)) bus ();

  boot_sequencer #(
    .NUM_CORES(2), .ADDR_W(32), .HOLD_CYCLES(16), .STAGGER(4), .RUN_CYCLES(1000)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic tick_to(input int k);
    while (n < k) tick();
  endtask

  task automatic push(input string tag, input logic [127:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [127:0] obs);
    string        t;
    logic [127:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic start_boot(input logic [63:0] addr);
    bus.boot_addr_in = addr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    n = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.boot_addr_in = '0;
    bus.core_halted = 2'b00;

    // Reset state
    push("rst_core_rst", 128'(2'b11));
    push("rst_busy", 128'(1'b0));
    push("rst_done", 128'(1'b0));
    push("rst_timeout", 128'(1'b0));
    push("rst_startPC", 128'(64'h0));
    push("rst_cycle_count", 128'(32'd0));
    repeat (3) @(posedge clk);
    #1;
    pop_check(128'(bus.core_rst));
    pop_check(128'(bus.busy));
    pop_check(128'(bus.done));
    pop_check(128'(bus.timeout));
    pop_check(128'(bus.startPC));
    pop_check(128'(bus.cycle_count));
    rst = 1'b0;
    tick();
    tick();

    // Scenario 1: boot, staggered release
    push("s1_busy", 128'(1'b1));
    push("s1_startPC", 128'(64'h00000100_00000000));
    push("s1_core_rst_hold", 128'(2'b11));
    start_boot(64'h00000100_00000000);
    pop_check(128'(bus.busy));
    pop_check(128'(bus.startPC));
    pop_check(128'(bus.core_rst));

    // Scenario 4: start and new address during HOLD are ignored
    tick_to(3);
    bus.start = 1'b1;
    bus.boot_addr_in = 64'h0000DEAD_0000DEAD;
    push("s4_busy", 128'(1'b1));
    push("s4_startPC", 128'(64'h00000100_00000000));
    tick();
    bus.start = 1'b0;
    pop_check(128'(bus.busy));
    pop_check(128'(bus.startPC));

    tick_to(15);
    push("s1_core_rst_t15", 128'(2'b11));
    pop_check(128'(bus.core_rst));
    push("s1_core_rst_t16", 128'(2'b10));
    tick();
    pop_check(128'(bus.core_rst));
    tick_to(19);
    push("s1_core_rst_t19", 128'(2'b10));
    pop_check(128'(bus.core_rst));
    push("s1_core_rst_t20", 128'(2'b00));
    tick();
    pop_check(128'(bus.core_rst));

    // Scenario 2: all halted after 50 run cycles
    tick_to(70);
    bus.core_halted = 2'b11;
    push("s2_done", 128'(1'b1));
    push("s2_timeout", 128'(1'b0));
    push("s2_core_rst", 128'(2'b11));
    push("s2_busy", 128'(1'b0));
    push("s2_cycle_count", 128'(PERF ? 32'd50 : 32'd0));
    tick();
    pop_check(128'(bus.done));
    pop_check(128'(bus.timeout));
    pop_check(128'(bus.core_rst));
    pop_check(128'(bus.busy));
    pop_check(128'(bus.cycle_count));
    bus.core_halted = 2'b00;
    repeat (3) tick();
    push("s2_done_held", 128'(1'b1));
    push("s2_startPC_held", 128'(64'h00000100_00000000));
    pop_check(128'(bus.done));
    pop_check(128'(bus.startPC));

    // Scenario 3: budget expiry exactly 1000 cycles after RUN entry
    push("s3_done_clr", 128'(1'b0));
    push("s3_startPC", 128'(64'h00000200_00000300));
    start_boot(64'h00000200_00000300);
    pop_check(128'(bus.done));
    pop_check(128'(bus.startPC));
    tick_to(1019);
    push("s3_done_early", 128'(1'b0));
    push("s3_core_rst_run", 128'(2'b00));
    pop_check(128'(bus.done));
    pop_check(128'(bus.core_rst));
    push("s3_done", 128'(1'b1));
    push("s3_timeout", 128'(1'b1));
    push("s3_core_rst", 128'(2'b11));
    push("s3_cycle_count", 128'(PERF ? 32'd1000 : 32'd0));
    tick();
    pop_check(128'(bus.done));
    pop_check(128'(bus.timeout));
    pop_check(128'(bus.core_rst));
    pop_check(128'(bus.cycle_count));

    // Scenario 6: halt and budget expiry on the same edge
    push("s6_timeout_clr", 128'(1'b0));
    start_boot(64'h00000400_00000500);
    pop_check(128'(bus.timeout));
    tick_to(1019);
    bus.core_halted = 2'b11;
    push("s6_done", 128'(1'b1));
    push("s6_timeout", 128'(1'b0));
    push("s6_cycle_count", 128'(PERF ? 32'd999 : 32'd0));
    tick();
    pop_check(128'(bus.done));
    pop_check(128'(bus.timeout));
    pop_check(128'(bus.cycle_count));
    bus.core_halted = 2'b00;

    // Scenario 5: RESET mid-RUN between edges
    start_boot(64'h00000600_00000700);
    tick_to(30);
    push("s5_core_rst_run", 128'(2'b00));
    pop_check(128'(bus.core_rst));
    #2;
    rst = 1'b1;
    push("s5_core_rst_async", 128'(2'b11));
    push("s5_busy_async", 128'(1'b0));
    push("s5_startPC_rst", 128'(64'h0));
    #1;
    pop_check(128'(bus.core_rst));
    pop_check(128'(bus.busy));
    pop_check(128'(bus.startPC));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Restart after reset; halt flags during HOLD/RELEASE must be ignored
    bus.core_halted = 2'b11;
    push("s5r_busy", 128'(1'b1));
    start_boot(64'h00000100_00000000);
    pop_check(128'(bus.busy));
    tick_to(15);
    push("s5r_core_rst_t15", 128'(2'b11));
    pop_check(128'(bus.core_rst));
    push("s5r_core_rst_t16", 128'(2'b10));
    tick();
    pop_check(128'(bus.core_rst));
    tick_to(19);
    bus.core_halted = 2'b00;
    push("s5r_busy_t19", 128'(1'b1));
    pop_check(128'(bus.busy));
    push("s5r_core_rst_t20", 128'(2'b00));
    tick();
    pop_check(128'(bus.core_rst));
    tick_to(25);
    push("s5r_running", 128'(1'b1));
    push("s5r_not_done", 128'(1'b0));
    pop_check(128'(bus.busy));
    pop_check(128'(bus.done));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
